// File: rtl/fp_add_tree.sv
// fp_add_tree: fully pipelined floating-point reduction tree.
// Each tree level is one combinational FP adder per operand pair followed by a
// register stage. data_valid rides a shift register of the same depth.
module fp_add_tree #(
  parameter int EXP   = 8,
  parameter int MANT  = 7,
  parameter int WIDTH = 16,
  parameter int ITEMS = 32
) (
  input  logic                        clock,
  input  logic                        clock_sreset,
  input  logic                        data_valid,
  input  logic [ITEMS-1:0][WIDTH-1:0] data,
  output logic                        result_valid,
  output logic [WIDTH-1:0]            result
);

  localparam int LEVELS = $clog2(ITEMS);
  localparam int NP     = 1 << LEVELS;   // leaves rounded up to a power of two
  localparam int MW     = MANT + 4;      // hidden bit + fraction + guard/round/sticky
  localparam int EMAX   = (1 << EXP) - 1;

  // Single adder node: flush-to-zero inputs, align with sticky, add/subtract,
  // normalise, round-to-nearest-even, then saturate to zero or infinity.
  function automatic logic [WIDTH-1:0] fp_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic             sa, sb, sl;
    logic [EXP-1:0]   ea, eb, el, es, d;
    logic [MW-1:0]    ml, ms, mask, sh, n;
    logic [MW:0]      sum;
    logic [MANT+1:0]  mr;
    logic [MANT-1:0]  frac;
    logic             rup, found;
    int               e, lz;
    logic [WIDTH-1:0] res;
    sa    = a[WIDTH-1];
    sb    = b[WIDTH-1];
    ea    = a[WIDTH-2 -: EXP];
    eb    = b[WIDTH-2 -: EXP];
    sl    = 1'b0;
    el    = '0;
    es    = '0;
    d     = '0;
    ml    = '0;
    ms    = '0;
    mask  = '0;
    sh    = '0;
    n     = '0;
    sum   = '0;
    mr    = '0;
    frac  = '0;
    rup   = 1'b0;
    found = 1'b0;
    e     = 0;
    lz    = 0;
    res   = '0;
    if (ea == '0 && eb == '0) begin
      res = '0;
    end else if (ea == '0) begin
      res = b;
    end else if (eb == '0) begin
      res = a;
    end else begin
      // Larger magnitude goes in ml; it also decides the result sign.
      if ({ea, a[MANT-1:0]} >= {eb, b[MANT-1:0]}) begin
        sl = sa;
        el = ea;
        es = eb;
        ml = {1'b1, a[MANT-1:0], 3'b000};
        ms = {1'b1, b[MANT-1:0], 3'b000};
      end else begin
        sl = sb;
        el = eb;
        es = ea;
        ml = {1'b1, b[MANT-1:0], 3'b000};
        ms = {1'b1, a[MANT-1:0], 3'b000};
      end
      d = el - es;
      if (int'(d) >= MANT + 3) begin
        sh = MW'(1'b1);   // only a sticky contribution survives
      end else begin
        mask = ~({MW{1'b1}} << d);
        sh   = (ms >> d) | MW'(|(ms & mask));
      end
      e = int'(el);
      if (sa == sb) begin
        sum = {1'b0, ml} + {1'b0, sh};
        if (sum[MW]) begin
          n = sum[MW:1] | MW'(sum[0]);
          e = e + 1;
        end else begin
          n = sum[MW-1:0];
        end
      end else begin
        n = ml - sh;
      end
      if (n == '0) begin
        res = '0;   // exact cancellation is always +0
      end else begin
        for (int i = MW - 1; i >= 0; i--) begin
          if (!found) begin
            if (n[i]) begin
              found = 1'b1;
            end else begin
              lz = lz + 1;
            end
          end
        end
        n   = n << lz;
        e   = e - lz;
        rup = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[MW-1:3]} + (MANT+2)'(rup);
        if (mr[MANT+1]) begin
          frac = mr[MANT:1];
          e    = e + 1;
        end else begin
          frac = mr[MANT-1:0];
        end
        if (e <= 0) begin
          res = {sl, {(WIDTH-1){1'b0}}};
        end else if (e >= EMAX) begin
          res = {sl, {EXP{1'b1}}, {MANT{1'b0}}};
        end else begin
          res = {sl, e[EXP-1:0], frac};
        end
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0]  leaf_s [NP];
  logic [WIDTH-1:0]  node_d [1:NP-1];
  logic [WIDTH-1:0]  node_q [1:NP-1];
  logic [LEVELS-1:0] valid_q;

  // Leaves beyond ITEMS are padded with +0 so the tree stays balanced.
  for (genvar k = 0; k < NP; k++) begin : g_leaf
    if (k < ITEMS) begin : g_used
      assign leaf_s[k] = data[k];
    end else begin : g_pad
      assign leaf_s[k] = '0;
    end
  end

  // Heap-ordered nodes: node i sums children 2i and 2i+1; node 1 is the root.
  for (genvar i = 1; i < NP; i++) begin : g_node
    if (2 * i >= NP) begin : g_bottom
      assign node_d[i] = fp_add(leaf_s[2*i-NP], leaf_s[2*i+1-NP]);
    end else begin : g_inner
      assign node_d[i] = fp_add(node_q[2*i], node_q[2*i+1]);
    end
  end

  // Pipeline registers and valid chain: load every cycle, clear under reset.
  always_ff @(posedge clock) begin
    if (!clock_sreset) begin
      for (int k = 1; k < NP; k++) begin
        node_q[k] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int k = 1; k < NP; k++) begin
        node_q[k] <= node_d[k];
      end
      valid_q <= LEVELS'({valid_q, data_valid});
    end
  end

  assign result       = node_q[1];
  assign result_valid = valid_q[LEVELS-1];

endmodule

// File: tb/tb_fp_add_tree.sv
// tb_fp_add_tree: directed vectors against a real-arithmetic reference tree.
module tb_fp_add_tree;
  localparam int EXP    = 8;
  localparam int MANT   = 7;
  localparam int WIDTH  = 16;
  localparam int ITEMS  = 32;
  localparam int LEVELS = 5;

  typedef logic [ITEMS-1:0][WIDTH-1:0] vec_t;
  typedef struct packed {
    logic        known;
    logic        rst;
    logic        v;
    logic [15:0] d;
  } ent_t;

  logic        clock = 1'b0;
  logic        clock_sreset;
  logic        data_valid;
  vec_t        data;
  logic        result_valid;
  logic [15:0] result;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t pipe [LEVELS];

  fp_add_tree #(.EXP(EXP), .MANT(MANT), .WIDTH(WIDTH), .ITEMS(ITEMS)) dut (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .data_valid   (data_valid),
    .data         (data),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clock = ~clock;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) begin
      for (int i = 0; i < n; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -n; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic real bf_to_real(input logic [15:0] x);
    real m;
    if (x[14:7] == 8'd0) return 0.0;
    m = (1.0 + real'(x[6:0]) / 128.0) * pow2(int'(x[14:7]) - 127);
    return x[15] ? -m : m;
  endfunction

  // Round an exact real to bfloat16, nearest-even, zero/inf saturation.
  function automatic logic [15:0] real_to_bf(input real val);
    logic s;
    real  a, sc, rem;
    int   e, fi;
    if (val == 0.0) return 16'h0000;
    s = (val < 0.0);
    a = s ? -val : val;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    sc  = a * 128.0;
    fi  = $rtoi(sc);
    rem = sc - real'(fi);
    if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
    if (fi == 256) begin fi = 128; e++; end
    e = e + 127;
    if (e <= 0) return {s, 15'd0};
    if (e >= 255) return {s, 8'hff, 7'd0};
    return {s, e[7:0], fi[6:0]};
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    if (a[14:7] == 8'd0 && b[14:7] == 8'd0) return 16'h0000;
    if (a[14:7] == 8'd0) return b;
    if (b[14:7] == 8'd0) return a;
    return real_to_bf(bf_to_real(a) + bf_to_real(b));
  endfunction

  function automatic logic [15:0] model_tree(input vec_t v);
    logic [15:0] t [ITEMS];
    for (int k = 0; k < ITEMS; k++) t[k] = v[k];
    for (int n = ITEMS; n > 1; n = n / 2) begin
      for (int i = 0; i < n / 2; i++) t[i] = model_add(t[2*i], t[2*i+1]);
    end
    return t[0];
  endfunction

  function automatic vec_t pattern(input int j);
    vec_t v;
    for (int k = 0; k < ITEMS; k++) begin
      v[k][15]   = ((k * 7 + j) % 3 == 0);
      v[k][14:7] = 8'(118 + (k * 5 + j) % 12);
      v[k][6:0]  = 7'((k * 37 + j * 11) % 128);
    end
    if (j % 4 == 3) v[j] = 16'h0000;
    if (j == 5) v[0][14:7] = 8'd140;
    return v;
  endfunction

  // Reference delay line: LEVELS entries, cleared by reset, fed every edge.
  initial begin
    for (int k = 0; k < LEVELS; k++) pipe[k] = '0;
    forever begin
      @(posedge clock);
      if (!clock_sreset) begin
        for (int k = 0; k < LEVELS; k++) begin
          pipe[k].known = 1'b1;
          pipe[k].rst   = 1'b1;
          pipe[k].v     = 1'b0;
          pipe[k].d     = 16'h0000;
        end
      end else begin
        for (int k = 0; k < LEVELS - 1; k++) pipe[k] = pipe[k+1];
        pipe[LEVELS-1].known = 1'b1;
        pipe[LEVELS-1].rst   = 1'b0;
        pipe[LEVELS-1].v     = data_valid;
        pipe[LEVELS-1].d     = model_tree(data);
      end
    end
  end

  // Compare DUT outputs to the reference every falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (pipe[0].known) begin
        n_cmp++;
        if (result_valid !== pipe[0].v) begin
          n_bad++;
          $display("FAIL pipe_valid t=%0t: result_valid=%b expected %b", $time, result_valid, pipe[0].v);
        end
        if (pipe[0].v || pipe[0].rst) begin
          n_cmp++;
          if (result !== pipe[0].d) begin
            n_bad++;
            $display("FAIL pipe_result t=%0t: result=%h expected %h", $time, result, pipe[0].d);
          end
        end
      end
    end
  end

  task automatic step(input vec_t v, input logic vld, input logic rstn);
    @(negedge clock);
    data         = v;
    data_valid   = vld;
    clock_sreset = rstn;
  endtask

  task automatic check_lit(input string name, input logic [15:0] exp_r,
                           input logic exp_v, input logic chk_r);
    n_cmp++;
    if (result_valid !== exp_v || (chk_r && result !== exp_r)) begin
      n_bad++;
      $display("FAIL %s: result=%h valid=%b expected result=%h valid=%b",
               name, result, result_valid, exp_r, exp_v);
    end
  endtask

  task automatic vec_check(input string name, input vec_t v, input logic [15:0] exp_r);
    step(v, 1'b1, 1'b1);
    repeat (5) step('0, 1'b0, 1'b1);
    check_lit(name, exp_r, 1'b1, 1'b1);
  endtask

  initial begin
    vec_t va, vb, v;
    clock_sreset = 1'b0;
    data_valid   = 1'b0;
    data         = '0;

    // Reset held for 5 cycles, then idle.
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    check_lit("reset_early", 16'h0000, 1'b0, 1'b1);
    repeat (3) step('0, 1'b0, 1'b0);
    check_lit("reset_late", 16'h0000, 1'b0, 1'b1);
    repeat (6) step('0, 1'b0, 1'b1);
    check_lit("idle_after_reset", 16'h0000, 1'b0, 1'b0);

    // Single vector.
    va = '0; va[0] = 16'h400e; va[27] = 16'h3f8e;
    vec_check("single", va, 16'h4055);
    step('0, 1'b0, 1'b1);
    check_lit("single_pulse_end", 16'h0000, 1'b0, 1'b0);

    // Back-to-back with a rounding tie.
    vb = '0; vb[0] = 16'h4055; vb[27] = 16'h408e;
    step(va, 1'b1, 1'b1);
    step(vb, 1'b1, 1'b1);
    repeat (4) step('0, 1'b0, 1'b1);
    check_lit("b2b_first", 16'h4055, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    check_lit("b2b_second_tie", 16'h40f8, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    check_lit("b2b_end", 16'h0000, 1'b0, 1'b0);

    // Cancellation and signs.
    v = '0; v[3] = 16'h3f80; v[4] = 16'hbf80; v[31] = 16'hc000;
    vec_check("cancel_sign", v, 16'hc000);
    v = '0;
    for (int k = 0; k < ITEMS / 2; k++) begin
      v[2*k]   = {1'b0, 8'(120 + k), 7'(k * 5)};
      v[2*k+1] = {1'b1, 8'(120 + k), 7'(k * 5)};
    end
    vec_check("all_pairs_cancel", v, 16'h0000);

    // Full-vector sums and overflow.
    for (int k = 0; k < ITEMS; k++) v[k] = 16'h3f80;
    vec_check("all_ones", v, 16'h4200);
    for (int k = 0; k < ITEMS; k++) v[k] = 16'h7f7f;
    vec_check("overflow_inf", v, 16'h7f80);
    check_lit("all_zero_model", model_tree('0), 1'b1, 1'b0);

    // Toggling valid, then a dense burst of mixed vectors.
    for (int j = 0; j < 12; j++) step(pattern(j), (j % 2 == 0), 1'b1);
    for (int j = 12; j < 18; j++) step(pattern(j), 1'b1, 1'b1);
    repeat (6) step('0, 1'b0, 1'b1);

    // Reset two cycles after a valid vector drops it.
    step(va, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    check_lit("midflight_dropped", 16'h0000, 1'b0, 1'b0);
    v = '0; v[3] = 16'h3f80; v[4] = 16'hbf80; v[31] = 16'hc000;
    vec_check("after_reset", v, 16'hc000);
    vec_check("after_reset_single", va, 16'h4055);
    repeat (3) step('0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_add_tree.md
Name: fp_add_tree

Overview:
- Fully pipelined floating-point reduction tree. Sums ITEMS packed floating-point operands (default bfloat16: 1/8/7) into one value of the same format.
- Used in the inference datapath after the multiplier array to reduce dot-product partial products.
- Accepts one new vector every clock. Result appears a fixed number of cycles later with a matching valid flag.

Parameters:
- EXP, 8, exponent field width; bias = 2^(EXP-1)-1.
- MANT, 7, stored mantissa (fraction) width; hidden leading 1 implied.
- WIDTH, 16, word width; must equal 1+EXP+MANT.
- ITEMS, 32, number of operands per vector; must be >= 2.

Ports:
- clock, input, 1, single system clock; all logic is rising-edge.
- clock_sreset, input, 1, synchronous active-low reset; 0 = reset, sampled on the rising clock edge.
- data_valid, input, 1, qualifies data this cycle.
- data, input, ITEMS x WIDTH (packed [ITEMS-1:0][WIDTH-1:0]), operand vector; element k = data[k].
- result_valid, output, 1, high when result holds a completed sum.
- result, output, WIDTH, sum of the ITEMS operands captured LEVELS cycles earlier.

Behaviour:
- Structure:
  - LEVELS = clog2(ITEMS).
  - If ITEMS is not a power of two, missing leaves are +0.
  - Level L adds adjacent pairs from level L-1 and registers the sums.
  - Each level is one combinational FP adder per pair plus one register stage.
- Latency and throughput:
  - Latency is exactly LEVELS cycles from sampling data/data_valid to result/result_valid (5 for ITEMS=32).
  - Throughput is one vector per cycle; no backpressure and no stall.
  - data_valid travels through a LEVELS-deep shift register alongside the data.
  - Data registers load every cycle regardless of valid; result contents are don't-care while result_valid=0.
- Reset:
  - While clock_sreset=0, all pipeline registers, the valid chain, result and result_valid clear to 0.
  - Reset mid-stream discards all in-flight vectors; no result_valid pulse may appear for them.
  - The first valid output appears LEVELS cycles after the first vector sampled post-reset.
- Adder arithmetic (each node):
  - Format is sign | exponent | fraction.
  - Exponent field 0 means zero: denormals are flushed to zero on input and output.
  - Align: shift the smaller-magnitude operand right by the exponent difference, keeping guard/round/sticky bits. A difference >= MANT+3 reduces that operand to sticky only.
  - Same signs: add mantissas. Carry-out -> shift right 1, exponent+1.
  - Opposite signs: subtract smaller from larger magnitude; result sign = sign of the larger magnitude. Normalize with a leading-zero count and left shift, decrementing the exponent.
  - Exact cancellation gives +0.
  - Rounding: round-to-nearest-even using guard/round/sticky. A rounding carry renormalises.
  - Underflow (exponent <= 0 after normalise) -> signed zero.
  - Overflow (exponent >= 2^EXP-1) -> signed infinity (exponent all ones, fraction 0).
  - Inf/NaN inputs are not supported; the output for them is unspecified but must not hang the pipeline.
  - Zero plus X = X exactly.
- Boundary conditions:
  - All-zero vector -> +0.
  - data_valid toggling every cycle -> result_valid reproduces the same pattern delayed LEVELS cycles.
  - Back-to-back vectors are independent; no state carries between them.

Test Plan:
- Reset: hold clock_sreset=0 for 5 cycles -> result=0, result_valid=0 throughout; release, all data 0, data_valid=0 -> result_valid stays 0.
- Single vector: data[0]=0x400e (2.21875), data[27]=0x3f8e (1.109375), others 0, data_valid=1 for 1 cycle -> exactly 5 cycles later result=0x4055 (3.328125), result_valid=1 for one cycle.
- Back-to-back with rounding: vector from the previous line, then next cycle data[0]=0x4055, data[27]=0x408e (3.328125+4.4375=7.765625, tie) -> consecutive outputs 0x4055 then 0x40f8, result_valid high 2 cycles.
- Cancellation and signs: data[3]=0x3f80, data[4]=0xbf80, data[31]=0xc000 -> result=0xc000 (-2.0); all pairs cancelling -> 0x0000.
- Full-vector sum: all 32 lanes 0x3f80 (1.0) -> 0x4200 (32.0); all lanes 0x7f7f (max) -> 0x7f80 (+inf).
- Reset mid-flight: assert clock_sreset=0 two cycles after a valid vector -> no result_valid pulse for that vector; subsequent vectors produce correct results with 5-cycle latency.
